// File: rtl/stream_mux.sv
// stream_mux: N-to-1 round-robin stream merger with a registered, source-tagged output.
// Optional build macro STREAM_MUX_LAST_LOCK_EN: once a non-last beat is accepted from an
// input, the arbiter stays on that input until its last beat is accepted.
module stream_mux #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned NUM_IN = 4,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN-1:0]       in_valid,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_last,
    output logic [NUM_IN-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_last,
    input  logic                    out_ready
);

    logic [SEL_W-1:0] rr_ptr;
    logic             load;
    logic             grant_exists;
    logic [SEL_W-1:0] grant_idx;
    logic [WIDTH-1:0] grant_data;
    logic             grant_last;
    logic             locked;
    int unsigned      rank;
    int unsigned      best_rank;

    assign load = !out_valid || out_ready;

`ifdef STREAM_MUX_LAST_LOCK_EN
    // Lock flag: set by an accepted non-last beat, cleared by an accepted last beat
    always_ff @(posedge clk) begin
        if (reset) begin
            locked <= 1'b0;
        end else if (load && grant_exists) begin
            locked <= !grant_last;
        end
    end
`else
    assign locked = 1'b0;
`endif

    // Round-robin arbitration: each input gets a rank equal to its distance after rr_ptr,
    // the lowest-ranked valid input wins (rr_ptr itself ranks last, so a sole requester still wins)
    always_comb begin
        grant_exists = 1'b0;
        grant_idx    = '0;
        grant_data   = '0;
        grant_last   = 1'b0;
        best_rank    = NUM_IN;
        rank         = 0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            rank = (i + NUM_IN - 32'(rr_ptr) - 1) % NUM_IN;
            if (in_valid[i] && (!locked || SEL_W'(i) == rr_ptr) && rank < best_rank) begin
                best_rank    = rank;
                grant_exists = 1'b1;
                grant_idx    = SEL_W'(i);
                grant_data   = in_data[i*WIDTH +: WIDTH];
                grant_last   = in_last[i];
            end
        end
    end

    // One-hot ready to the granted input; held low while reset is asserted
    always_comb begin
        in_ready = '0;
        if (load && grant_exists && !reset) begin
            in_ready[grant_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            out_last  <= 1'b0;
            rr_ptr    <= SEL_W'(NUM_IN - 1);
        end else if (load) begin
            if (grant_exists) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                out_last  <= grant_last;
                rr_ptr    <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_stream_mux.sv
// tb_stream_mux: scoreboard bench for stream_mux; lock checks follow STREAM_MUX_LAST_LOCK_EN.
module tb_stream_mux;

    localparam int W = 16;
    localparam int N = 4;
    localparam int S = 2;
`ifdef STREAM_MUX_LAST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   in_valid = '0;
    logic [N*W-1:0] in_data = '0;
    logic [N-1:0]   in_last = '0;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [S-1:0]   out_sel;
    logic           out_last;
    logic           out_ready = 1'b0;

    always #5 clk = ~clk;

    stream_mux #(.WIDTH(W), .NUM_IN(N), .SEL_W(S)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sel(out_sel), .out_last(out_last),
        .out_ready(out_ready)
    );

    typedef struct packed {
        logic [S-1:0] sel;
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    beat_t        sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    logic         m_valid, m_last, m_lock;
    logic [S-1:0] m_rr, m_sel;
    logic [W-1:0] m_data;
    logic [W-1:0] wd[N];
    logic [N-1:0] rdy_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_last  = 1'b0;
        m_lock  = 1'b0;
        m_rr    = S'(N - 1);
        m_sel   = '0;
        m_data  = '0;
        sb.delete();
    endtask

    task automatic set_words(input logic [W-1:0] base);
        for (int i = 0; i < N; i++) wd[i] = base + W'(i);
    endtask

    // One clock: drive at negedge, check just after, advance model on the posedge
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] lst, input logic ordy,
                        input logic rst);
        logic         ld, g_ok;
        int           g, j;
        logic [N-1:0] exp_rdy;
        beat_t        b;
        reset     = rst;
        in_valid  = v;
        in_last   = lst;
        out_ready = ordy;
        for (int i = 0; i < N; i++) in_data[i*W +: W] = wd[i];
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_data", out_data, m_data);
        check("out_sel", out_sel, m_sel);
        check("out_last", out_last, m_last);
        if (m_valid && ordy && !rst) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                b = sb.pop_front();
                check("sb_data", out_data, b.data);
                check("sb_sel", out_sel, b.sel);
                check("sb_last", out_last, b.last);
            end
        end
        ld   = !m_valid || ordy;
        g_ok = 1'b0;
        g    = 0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(m_rr) + k) % N;
            if (!g_ok && v[j] && (!m_lock || j == int'(m_rr))) begin
                g_ok = 1'b1;
                g    = j;
            end
        end
        exp_rdy = '0;
        if (!rst && ld && g_ok) exp_rdy[g] = 1'b1;
        rdy_seen = in_ready;
        check("in_ready", in_ready, exp_rdy);
        if (exp_rdy != 0) begin
            b.sel  = S'(g);
            b.data = wd[g];
            b.last = lst[g];
            sb.push_back(b);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else if (ld) begin
            if (g_ok) begin
                m_valid = 1'b1;
                m_data  = wd[g];
                m_sel   = S'(g);
                m_last  = lst[g];
                m_rr    = S'(g);
                m_lock  = LOCK_EN && !lst[g];
            end else begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
    endtask

    initial begin
        set_words('0);
        model_reset();
        in_valid = '1;
        @(posedge clk);
        @(negedge clk);

        // Reset held with all inputs requesting
        step(4'b1111, '0, 1'b1, 1'b1);
        check("rst_ready", rdy_seen, 4'b0000);
        step(4'b1111, '0, 1'b1, 1'b1);
        check("rst_ready", rdy_seen, 4'b0000);
        check("rst_data", out_data, 16'h0000);

        // Round-robin with every input valid
        set_words(16'hA000);
        step(4'b1111, '0, 1'b1, 1'b0);
        check("first_grant", rdy_seen, 4'b0001);
        for (int c = 1; c < 8; c++) step(4'b1111, '0, 1'b1, 1'b0);
        check("rr_valid", out_valid, 1'b1);
        check("rr_sel", out_sel, 3);

        // Backpressure on a word from input 2
        wd[2] = 16'h1234;
        step(4'b0100, '0, 1'b1, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(4'b1111, '0, 1'b0, 1'b0);
            check("bp_ready", rdy_seen, 4'b0000);
            check("bp_data", out_data, 16'h1234);
            check("bp_sel", out_sel, 2);
        end
        step(4'b1111, '0, 1'b1, 1'b0);
        check("bp_release", rdy_seen, 4'b1000);

        // Sole requester, then skipping over idle inputs
        set_words(16'hA000);
        for (int c = 0; c < 4; c++) begin
            step(4'b0100, '0, 1'b1, 1'b0);
            check("sole_ready", rdy_seen, 4'b0100);
        end
        for (int c = 0; c < 4; c++) begin
            step(4'b1001, '0, 1'b1, 1'b0);
            check("skip_ready", rdy_seen, (c % 2 == 0) ? 4'b1000 : 4'b0001);
        end

        // Idle: valid drops one cycle after the last accept, data holds
        step(4'b0000, '0, 1'b1, 1'b0);
        check("idle_valid", out_valid, 1'b0);
        check("idle_hold", out_data, 16'hA000);
        step(4'b0000, '0, 1'b1, 1'b0);

        // Reset while a stalled word is held
        step(4'b0010, '0, 1'b1, 1'b0);
        step(4'b1111, '0, 1'b0, 1'b0);
        step(4'b1111, '0, 1'b0, 1'b1);
        check("midrst_valid", out_valid, 1'b0);
        check("midrst_data", out_data, 16'h0000);
        step(4'b1111, '0, 1'b1, 1'b0);
        check("midrst_grant", rdy_seen, 4'b0001);

        // Burst from input 1 while input 0 also requests
        set_words(16'hB000);
        step(4'b0011, 4'b0000, 1'b1, 1'b0);
        check("burst_b1", rdy_seen, 4'b0010);
        step(4'b0011, 4'b0000, 1'b1, 1'b0);
        check("burst_b2", rdy_seen, LOCK_EN ? 4'b0010 : 4'b0001);
        step(4'b0011, 4'b0010, 1'b1, 1'b0);
        step(4'b0001, 4'b0000, 1'b1, 1'b0);
        check("burst_after", rdy_seen, 4'b0001);
        step(4'b0000, '0, 1'b1, 1'b0);

        // Random traffic with random backpressure
        for (int c = 0; c < 80; c++) begin
            for (int i = 0; i < N; i++) wd[i] = W'($urandom);
            step(N'($urandom), N'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        end
        step(4'b0000, '0, 1'b1, 1'b0);
        step(4'b0000, '0, 1'b1, 1'b0);
        check("sb_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
